key_debounce: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 23 ++
 rtl/key_debounce_ch.sv | 142 ++++++++++++++
 rtl/key_debounce_chk.sv | 21 ++
 rtl/key_debounce.sv | 48 ++++
 tb/tb_key_debounce.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton conditioning front end:
// per-channel FSM encoding and the default 50 MHz timing constants.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REPEAT   = 2'd2
  } key_state_e;

  // 20 ms debounce, 0.5 s hold before repeat, 10 Hz repeat rate at 50 MHz
  localparam int DEF_STABLE_CYCLES = 1000000;
  localparam int DEF_CNT_W         = 20;
  localparam int DEF_HOLD_CYCLES   = 25000000;
  localparam int DEF_REPEAT_CYCLES = 5000000;

  function automatic int rcnt_width(input int hold_cycles, input int repeat_cycles);
    int longest;
    longest = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: 2-flop synchroniser, stability counter, and the
// RELEASED/HOLD/REPEAT FSM that generates press, repeat and release pulses.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int                RCNT_W      = rcnt_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam bit                REP_ON      = (REPEAT_EN != 0);
  localparam logic [CNT_W-1:0]  DCNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] HOLD_LAST   = RCNT_W'(HOLD_CYCLES - 1);
  localparam logic [RCNT_W-1:0] REPEAT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

  logic              sync1_r;
  logic              sync_n_r;
  logic [CNT_W-1:0]  dcnt_r;
  logic [CNT_W-1:0]  dcnt_nxt_s;
  logic              level_r;
  logic              press_r;
  logic              release_r;
  key_state_e        state_r;
  key_state_e        state_nxt_s;
  logic [RCNT_W-1:0] rcnt_r;
  logic [RCNT_W-1:0] rcnt_nxt_s;
  logic              pressed_raw_s;
  logic              accept_s;
  logic              rise_s;
  logic              fall_s;
  logic              tick_s;

  // Two-flop synchroniser; idles at 1 (released) so reset never looks like a press
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_r  <= 1'b1;
      sync_n_r <= 1'b1;
    end else begin
      sync1_r  <= key_n;
      sync_n_r <= sync1_r;
    end
  end

  // Stability counter: any return to the accepted level restarts the count
  always_comb begin
    pressed_raw_s = ~sync_n_r;
    accept_s      = 1'b0;
    dcnt_nxt_s    = '0;
    if (pressed_raw_s != level_r) begin
      if (dcnt_r == DCNT_LAST) begin
        accept_s   = 1'b1;
        dcnt_nxt_s = '0;
      end else begin
        dcnt_nxt_s = dcnt_r + CNT_W'(1);
      end
    end else begin
      dcnt_nxt_s = '0;
    end
    rise_s = accept_s & ~level_r;
    fall_s = accept_s &  level_r;
  end

  // Next-state logic; an accepted release always wins over a repeat tick
  always_comb begin
    state_nxt_s = state_r;
    rcnt_nxt_s  = rcnt_r;
    tick_s      = 1'b0;
    case (state_r)
      ST_RELEASED: begin
        rcnt_nxt_s = '0;
        if (rise_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_RELEASED;
        end
      end
      ST_HOLD: begin
        if (fall_s) begin
          state_nxt_s = ST_RELEASED;
          rcnt_nxt_s  = '0;
        end else if (REP_ON && (rcnt_r == HOLD_LAST)) begin
          state_nxt_s = ST_REPEAT;
          rcnt_nxt_s  = '0;
          tick_s      = 1'b1;
        end else if (REP_ON) begin
          rcnt_nxt_s = rcnt_r + RCNT_W'(1);
        end else begin
          rcnt_nxt_s = '0;
        end
      end
      ST_REPEAT: begin
        if (fall_s) begin
          state_nxt_s = ST_RELEASED;
          rcnt_nxt_s  = '0;
        end else if (rcnt_r == REPEAT_LAST) begin
          rcnt_nxt_s = '0;
          tick_s     = 1'b1;
        end else begin
          rcnt_nxt_s = rcnt_r + RCNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_RELEASED;
        rcnt_nxt_s  = '0;
      end
    endcase
  end

  // Channel state and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dcnt_r    <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      state_r   <= ST_RELEASED;
      rcnt_r    <= '0;
    end else begin
      dcnt_r    <= dcnt_nxt_s;
      level_r   <= level_r ^ accept_s;
      press_r   <= rise_s | tick_s;
      release_r <= fall_s;
      state_r   <= state_nxt_s;
      rcnt_r    <= rcnt_nxt_s;
    end
  end

  assign key_level   = level_r;
  assign key_press   = press_r;
  assign key_release = release_r;

endmodule

// File: rtl/key_debounce_chk.sv
// Output invariants of the key conditioning block, checked while out of reset.
module key_debounce_chk #(
  parameter int NUM_KEYS = 4
) (
  input logic                clk,
  input logic                resetn,
  input logic [NUM_KEYS-1:0] key_level,
  input logic [NUM_KEYS-1:0] key_press,
  input logic [NUM_KEYS-1:0] key_release
);

  a_no_press_and_release: assert property (@(posedge clk) disable iff (!resetn)
    (key_press & key_release) == '0);

  a_press_implies_level: assert property (@(posedge clk) disable iff (!resetn)
    (key_press & ~key_level) == '0);

  a_release_implies_no_level: assert property (@(posedge clk) disable iff (!resetn)
    (key_release & key_level) == '0);

endmodule

// File: rtl/key_debounce.sv
// DE-board KEY conditioning: NUM_KEYS independent debounced channels giving
// an active-high level plus single-cycle press/release strobes.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W),
      .REPEAT_EN     (REPEAT_EN),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk         (CLOCK_50),
      .resetn      (resetn),
      .key_n       (KEY[g]),
      .key_level   (key_level[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g])
    );
  end

  key_debounce_chk #(
    .NUM_KEYS (NUM_KEYS)
  ) u_chk (
    .clk         (CLOCK_50),
    .resetn      (resetn),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: two instances (repeat off / on) share stimulus and are
// compared every cycle to a timestamp-based model, plus directed literal checks.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int S  = 8;
  localparam int CW = 4;
  localparam int H  = 20;
  localparam int R  = 6;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NK-1:0] KEY;
  logic [NK-1:0] lvl0, prs0, rel0;
  logic [NK-1:0] lvl1, prs1, rel1;

  always #5 clk = ~clk;

  key_debounce #(.NUM_KEYS(NK), .STABLE_CYCLES(S), .CNT_W(CW), .REPEAT_EN(0),
                 .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut0 (
    .CLOCK_50(clk), .resetn(resetn), .KEY(KEY),
    .key_level(lvl0), .key_press(prs0), .key_release(rel0));

  key_debounce #(.NUM_KEYS(NK), .STABLE_CYCLES(S), .CNT_W(CW), .REPEAT_EN(1),
                 .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut1 (
    .CLOCK_50(clk), .resetn(resetn), .KEY(KEY),
    .key_level(lvl1), .key_press(prs1), .key_release(rel1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a level is accepted once the synced input has disagreed with it for
  // S consecutive edges; repeats fall at H, H+R, H+2R... edges after acceptance.
  int          edge_no = 0;
  bit          model_valid = 1'b0;
  logic [NK-1:0] m_s1, m_s2, m_lvl, m_p0, m_p1, m_rel;
  int          m_start [NK];
  int          m_acc   [NK];

  always @(posedge clk) begin
    logic [NK-1:0] old;
    logic          raw;
    int            d;
    if (!resetn) begin
      m_s1 = '1; m_s2 = '1; m_lvl = '0; m_p0 = '0; m_p1 = '0; m_rel = '0;
      for (int i = 0; i < NK; i++) begin
        m_start[i] = -1;
        m_acc[i]   = 0;
      end
    end else begin
      old = m_lvl;
      for (int i = 0; i < NK; i++) begin
        raw = ~m_s2[i];
        if (raw != m_lvl[i]) begin
          if (m_start[i] < 0) m_start[i] = edge_no;
          if (edge_no - m_start[i] + 1 == S) begin
            m_lvl[i]   = raw;
            m_start[i] = -1;
          end
        end else begin
          m_start[i] = -1;
        end
      end
      m_s2  = m_s1;
      m_s1  = KEY;
      m_p0  = m_lvl & ~old;
      m_rel = ~m_lvl & old;
      for (int i = 0; i < NK; i++) begin
        if (m_p0[i]) m_acc[i] = edge_no;
        d = edge_no - m_acc[i];
        m_p1[i] = m_p0[i] || (m_lvl[i] && old[i] && d >= H && ((d - H) % R) == 0);
      end
    end
    edge_no++;
    model_valid = 1'b1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_level0",   lvl0, m_lvl);
      check("model_press0",   prs0, m_p0);
      check("model_release0", rel0, m_rel);
      check("model_level1",   lvl1, m_lvl);
      check("model_press1",   prs1, m_p1);
      check("model_release1", rel1, m_rel);
    end
  end

  int pos_q[$];

  function automatic int qat(input int idx);
    if (idx < pos_q.size()) return pos_q[idx];
    else return -1;
  endfunction

  // Watch one key for ncyc samples; n=1 is the sample after the first edge
  task automatic observe(input int ncyc, input int k, input bit rep,
                         output int npress, output int nrel, output int first_chg);
    logic start_lvl;
    npress = 0; nrel = 0; first_chg = -1;
    pos_q.delete();
    start_lvl = lvl0[k];
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (rep ? prs1[k] : prs0[k]) begin
        npress++;
        pos_q.push_back(n);
      end
      if (rep ? rel1[k] : rel0[k]) nrel++;
      if (first_chg < 0 && lvl0[k] != start_lvl) first_chg = n;
    end
  endtask

  initial begin
    int np, nr, fl, first, first3, relpos, late;
    logic seen;

    // Reset with all keys held down
    resetn = 1'b0;
    KEY    = 4'b0000;
    repeat (4) begin
      @(negedge clk);
      check("reset_level",   lvl0, 4'b0000);
      check("reset_press",   prs0, 4'b0000);
      check("reset_release", rel0, 4'b0000);
    end
    resetn = 1'b1;
    first = -1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (first < 0 && prs0 == 4'b1111) first = n;
    end
    check("held_through_reset_press_edge", first, 10);
    check("held_through_reset_level", lvl0, 4'b1111);
    KEY = 4'b1111;
    repeat (30) @(negedge clk);

    // Clean press on KEY[0]
    KEY[0] = 1'b0;
    observe(50, 0, 1'b0, np, nr, fl);
    check("press_latency", fl, 10);
    check("press_pulse_count", np, 1);
    check("press_no_release", nr, 0);

    // Release on KEY[0]
    KEY[0] = 1'b1;
    observe(30, 0, 1'b0, np, nr, fl);
    check("release_latency", fl, 10);
    check("release_pulse_count", nr, 1);
    check("release_no_press", np, 0);

    // Bounce: 3 low / 2 high bursts never reach S stable cycles
    seen = 1'b0;
    for (int r = 0; r < 8; r++) begin
      KEY[0] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        seen = seen | lvl0[0] | prs0[0] | rel0[0];
      end
      KEY[0] = 1'b1;
      repeat (2) begin
        @(negedge clk);
        seen = seen | lvl0[0] | prs0[0] | rel0[0];
      end
    end
    repeat (15) begin
      @(negedge clk);
      seen = seen | lvl0[0] | prs0[0] | rel0[0];
    end
    check("bounce_rejected", seen, 1'b0);

    // Auto-repeat on KEY[2]: pulses at accept +0, +20, +26 ... +56
    KEY[2] = 1'b0;
    observe(70, 2, 1'b1, np, nr, fl);
    check("repeat_pulse_count", np, 8);
    check("repeat_accept", qat(0), 10);
    check("repeat_first_tick", qat(1), 30);
    check("repeat_second_tick", qat(2), 36);
    check("repeat_last_tick", qat(7), 66);
    KEY[2] = 1'b1;
    relpos = -1;
    late   = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (relpos >= 0 && prs1[2]) late++;
      if (relpos < 0 && rel1[2]) relpos = n;
    end
    check("repeat_release_edge", relpos, 10);
    check("repeat_no_press_after_release", late, 0);

    // Simultaneous press on KEY[1] and KEY[3]
    KEY = 4'b0101;
    first  = -1;
    first3 = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (first < 0 && prs0[1]) first = n;
      if (first3 < 0 && prs0[3]) first3 = n;
    end
    check("simul_key1_edge", first, 10);
    check("simul_key3_edge", first3, 10);
    KEY = 4'b1111;
    repeat (30) @(negedge clk);

    // Reset for one cycle while KEY[1] count is at 5
    KEY[1] = 1'b0;
    repeat (7) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midop_reset_level", lvl0, 4'b0000);
    resetn = 1'b1;
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (first < 0 && prs0[1]) first = n;
    end
    check("midop_reset_press_edge", first, 10);
    KEY = 4'b1111;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
